board_store: RTL and testbench

//  Occupancy memory for the 10x20 playfield; the storage end of the game FSM's board read/write port.

---
 rtl/board_store.sv | 131 +++++++++++++
 tb/tb_board_store.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/board_store.sv
// rtl/board_store.sv - 10x20 playfield occupancy store with collision/VGA reads and full-row clear engine
// Rows are COLS-bit registers; the clear engine scans bottom-up and shifts everything above a full row down.
module board_store #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] board_rx,
  input  logic [4:0] board_ry,
  output logic       board_rdata,
  input  logic       board_we,
  input  logic [3:0] board_wx,
  input  logic [4:0] board_wy,
  input  logic       board_wdata,
  input  logic       wipe,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [4:0] lines_cleared,
  input  logic [3:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_cell,
  output logic       top_occupied
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_SCAN  = 2'd1;
  localparam logic [1:0] C_SHIFT = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];
  logic [1:0]      state_q, state_d;
  logic [4:0]      r_q, r_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      lines_q, lines_d;
  logic            vga_q, vga_d;
  logic            rd_ok, wr_ok, vga_ok;

  assign rd_ok  = (int'(board_rx) < COLS) && (int'(board_ry) < ROWS);
  assign wr_ok  = (int'(board_wx) < COLS) && (int'(board_wy) < ROWS);
  assign vga_ok = (int'(vga_x) < COLS) && (int'(vga_y) < ROWS);

  // Off-board collision reads look like walls to the game FSM.
  assign board_rdata   = rd_ok ? rows_q[board_ry][board_rx] : 1'b1;
  assign clear_busy    = (state_q != C_IDLE);
  assign clear_done    = (state_q == C_DONE);
  assign lines_cleared = lines_q;
  assign vga_cell      = vga_q;
  assign top_occupied  = |rows_q[0];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    case (state_q)
      C_IDLE: begin
        if (clear_start) begin
          r_d     = 5'(ROWS - 1);
          cnt_d   = '0;
          state_d = C_SCAN;
        end
      end
      C_SCAN: begin
        if (&rows_q[r_q]) begin
          state_d = C_SHIFT;
        end else if (r_q == '0) begin
          state_d = C_DONE;
        end else begin
          r_d = r_q - 5'd1;
        end
      end
      C_SHIFT: begin
        if (cnt_q != 5'(ROWS)) begin
          cnt_d = cnt_q + 5'd1;
        end
        state_d = C_SCAN;
      end
      default: begin
        lines_d = cnt_q;
        state_d = C_IDLE;
      end
    endcase
    if (wipe) begin
      state_d = C_IDLE;
    end
  end

  always_comb begin
    rows_d = rows_q;
    if (wipe) begin
      for (int y = 0; y < ROWS; y++) begin
        rows_d[y] = '0;
      end
    end else if (state_q == C_SHIFT) begin
      // The same r is rescanned next cycle, so stacked full rows are each caught.
      for (int y = 0; y < ROWS; y++) begin
        if (y == 0) begin
          rows_d[y] = '0;
        end else if (y <= int'(r_q)) begin
          rows_d[y] = rows_q[y-1];
        end
      end
    end else if (board_we && wr_ok && !clear_busy) begin
      rows_d[board_wy][board_wx] = board_wdata;
    end
  end

  assign vga_d = vga_ok ? rows_q[vga_y][vga_x] : 1'b0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rows_q  <= '{default: '0};
      state_q <= C_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      vga_q   <= 1'b0;
    end else begin
      rows_q  <= rows_d;
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      vga_q   <= vga_d;
    end
  end

endmodule

// File: tb/tb_board_store.sv
// tb/tb_board_store.sv - directed bench for board_store
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after a rising edge.
module tb_board_store;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] board_rx = '0;
  logic [4:0] board_ry = '0;
  logic       board_rdata;
  logic       board_we = 1'b0;
  logic [3:0] board_wx = '0;
  logic [4:0] board_wy = '0;
  logic       board_wdata = 1'b0;
  logic       wipe = 1'b0;
  logic       clear_start = 1'b0;
  logic       clear_busy;
  logic       clear_done;
  logic [4:0] lines_cleared;
  logic [3:0] vga_x = '0;
  logic [4:0] vga_y = '0;
  logic       vga_cell;
  logic       top_occupied;

  int vectors = 0;
  int errors = 0;
  int lat;
  int dones;

  board_store dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
    .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
    .wipe(wipe), .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .lines_cleared(lines_cleared), .vga_x(vga_x), .vga_y(vga_y), .vga_cell(vga_cell),
    .top_occupied(top_occupied)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int x, input int y, output logic v);
    board_rx = 4'(x);
    board_ry = 5'(y);
    #1 v = board_rdata;
  endtask

  task automatic count_occ(input int y_lo, input int y_hi, output int n);
    logic v;
    n = 0;
    for (int y = y_lo; y <= y_hi; y++)
      for (int x = 0; x < 10; x++) begin
        rd(x, y, v);
        if (v !== 1'b0) n++;
      end
  endtask

  task automatic wr(input int x, input int y, input logic d);
    @(negedge CLOCK_50);
    board_we = 1'b1; board_wx = 4'(x); board_wy = 5'(y); board_wdata = d;
    @(negedge CLOCK_50);
    board_we = 1'b0;
  endtask

  task automatic fill_row(input int y);
    for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
  endtask

  // Returns n such that clear_done is first seen by edge T+n; 999 if it never comes.
  task automatic start_and_wait(output int n);
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge CLOCK_50);
      n++;
      if (clear_done) break;
    end
    if (!clear_done) n = 999;
  endtask

  initial begin
    logic v;
    int n;

    // Reset state
    #25 resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_top", top_occupied, 0);
    rd(0, 0, v);
    check("rst_rd00", v, 0);

    // Single write and both read ports
    wr(3, 19, 1'b1);
    rd(3, 19, v);
    check("wr_rd_3_19", v, 1);
    rd(10, 0, v);
    check("oob_x_rd", v, 1);
    rd(0, 20, v);
    check("oob_y_rd", v, 1);
    vga_x = 4'd3; vga_y = 5'd19;
    @(posedge CLOCK_50); #1;
    check("vga_3_19", vga_cell, 1);
    vga_x = 4'd10; vga_y = 5'd0;
    @(posedge CLOCK_50); #1;
    check("vga_oob", vga_cell, 0);
    wr(15, 3, 1'b1);
    count_occ(0, 18, n);
    check("oob_write_ignored", n, 0);

    // One full row plus a stray cell above it
    fill_row(19);
    wr(0, 18, 1'b1);
    start_and_wait(lat);
    check("k1_latency", lat, 23);
    @(negedge CLOCK_50);
    check("k1_lines", lines_cleared, 1);
    check("k1_done_width", clear_done, 0);
    rd(0, 19, v);
    check("k1_cell_0_19", v, 1);
    rd(0, 18, v);
    check("k1_cell_0_18", v, 0);
    count_occ(0, 18, n);
    check("k1_upper_empty", n, 0);

    // Four stacked full rows; remove the leftover cell first
    wr(0, 19, 1'b0);
    for (int y = 16; y < 20; y++) fill_row(y);
    start_and_wait(lat);
    check("k4_latency", lat, 29);
    @(negedge CLOCK_50);
    check("k4_done_width", clear_done, 0);
    check("k4_busy_after", clear_busy, 0);
    check("k4_lines", lines_cleared, 4);
    count_occ(0, 19, n);
    check("k4_all_empty", n, 0);

    // Write and re-start during a pass are both ignored
    fill_row(19);
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    @(negedge CLOCK_50);
    clear_start = 1'b0;
    @(negedge CLOCK_50);
    board_we = 1'b1; board_wx = 4'd5; board_wy = 5'd5; board_wdata = 1'b1; clear_start = 1'b1;
    @(negedge CLOCK_50);
    board_we = 1'b0; clear_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLOCK_50);
      if (clear_done) dones++;
    end
    check("busy_done_count", dones, 1);
    check("busy_lines", lines_cleared, 1);
    rd(5, 5, v);
    check("busy_write_blocked", v, 0);

    // Wipe beats a simultaneous write
    wr(2, 0, 1'b1);
    check("top_set", top_occupied, 1);
    @(negedge CLOCK_50);
    wipe = 1'b1; board_we = 1'b1; board_wx = 4'd1; board_wy = 5'd1; board_wdata = 1'b1;
    @(negedge CLOCK_50);
    wipe = 1'b0; board_we = 1'b0;
    check("top_wiped", top_occupied, 0);
    count_occ(0, 19, n);
    check("wipe_all_empty", n, 0);

    // Reset asserted in C_SHIFT
    fill_row(19);
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    @(posedge CLOCK_50);
    #1 check("shift_busy", clear_busy, 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", clear_busy, 0);
    check("rst_mid_lines", lines_cleared, 0);
    check("rst_mid_top", top_occupied, 0);
    count_occ(0, 19, n);
    check("rst_mid_empty", n, 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_mid_idle", clear_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
